addsub_arb: RTL and testbench

Two-port arbiter and sequencer for the shared 16-bit add/subtract unit of the microcontroller datapath. Two requesters (port 0: execute stage, port 1: address/loop-counter unit) present operand pairs and an operation. The block picks one, registers its operands onto the adder inputs for one cycle, and captures the adder's combinational result into that requester's result registers. The adder itself stays outside this block; it connects through the `alu_*` ports.

---
 rtl/addsub_arb.sv | 124 ++++++++++++
 tb/tb_addsub_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arb.sv
// Two-port arbiter/sequencer in front of a shared external 16-bit add/subtract unit.
// Latency: gnt one cycle after req is sampled, done one cycle after gnt (one op per 2 cycles peak).
// Backpressure: requests are only sampled in IDLE; requests arriving during EXEC are ignored, not queued.
module addsub_arb #(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic [15:0] r0_a,
    input  logic [15:0] r0_b,
    input  logic [15:0] r1_a,
    input  logic [15:0] r1_b,
    input  logic        r0_add,
    input  logic        r1_add,
    input  logic        r0_sign,
    input  logic        r1_sign,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_done,
    output logic        r1_done,
    output logic [15:0] r0_y,
    output logic [15:0] r1_y,
    output logic        r0_carry,
    output logic        r1_carry,
    output logic        r0_over,
    output logic        r1_over,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_as,
    output logic        alu_sign,
    input  logic [15:0] alu_y,
    input  logic        alu_carry,
    input  logic        alu_over,
    output logic        busy,
    output logic [15:0] op_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state;
    logic   owner;   // port whose operands are currently on the adder
    logic   last;    // port that completed most recently (round-robin pointer)
    logic   win;     // port selected if a request is sampled this edge

    // Winner selection: on a tie round-robin favours the port that did not go last
    always_comb begin
        win = 1'b0;
        if (r0_req && r1_req) begin
            win = RR ? ~last : 1'b0;
        end else begin
            win = ~r0_req;
        end
    end

    // Sequencer FSM: grant and latch operands in IDLE, capture adder result in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            op_cnt   <= 16'h0000;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            busy     <= 1'b0;
            alu_a    <= 16'h0000;
            alu_b    <= 16'h0000;
            alu_as   <= 1'b0;
            alu_sign <= 1'b0;
            r0_y     <= 16'h0000;
            r1_y     <= 16'h0000;
            r0_carry <= 1'b0;
            r1_carry <= 1'b0;
            r0_over  <= 1'b0;
            r1_over  <= 1'b0;
        end else begin
            // pulses default low; only the branch that fires raises them
            r0_gnt  <= 1'b0;
            r1_gnt  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        alu_a    <= win ? r1_a    : r0_a;
                        alu_b    <= win ? r1_b    : r0_b;
                        alu_as   <= win ? r1_add  : r0_add;
                        alu_sign <= win ? r1_sign : r0_sign;
                        owner    <= win;
                        r0_gnt   <= ~win;
                        r1_gnt   <= win;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        r1_y     <= alu_y;
                        r1_carry <= alu_carry;
                        r1_over  <= alu_over;
                        r1_done  <= 1'b1;
                    end else begin
                        r0_y     <= alu_y;
                        r0_carry <= alu_carry;
                        r0_over  <= alu_over;
                        r0_done  <= 1'b1;
                    end
                    op_cnt <= op_cnt + 16'd1;
                    last   <= owner;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arb.sv
// Directed bench: round-robin and fixed-priority instances share one stimulus stream.
// Each instance drives its own behavioural adder (sub carry = borrow, over only when signed).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_addsub_arb;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r1_req;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic        r0_add, r1_add, r0_sign, r1_sign;

    // round-robin instance outputs
    logic        rr_r0_gnt, rr_r1_gnt, rr_r0_done, rr_r1_done;
    logic [15:0] rr_r0_y, rr_r1_y;
    logic        rr_r0_carry, rr_r1_carry, rr_r0_over, rr_r1_over;
    logic [15:0] rr_alu_a, rr_alu_b, rr_alu_y, rr_op_cnt;
    logic        rr_alu_as, rr_alu_sign, rr_alu_carry, rr_alu_over, rr_busy;

    // fixed-priority instance outputs
    logic        fp_r0_gnt, fp_r1_gnt, fp_r0_done, fp_r1_done;
    logic [15:0] fp_r0_y, fp_r1_y;
    logic        fp_r0_carry, fp_r1_carry, fp_r0_over, fp_r1_over;
    logic [15:0] fp_alu_a, fp_alu_b, fp_alu_y, fp_op_cnt;
    logic        fp_alu_as, fp_alu_sign, fp_alu_carry, fp_alu_over, fp_busy;

    int checks = 0;
    int errors = 0;

    // behavioural adder: returns {carry, over, y}
    function automatic logic [17:0] adder(input logic [15:0] a, input logic [15:0] b,
                                          input logic as, input logic sgn);
        logic [16:0] s;
        logic [15:0] y;
        logic        c, ov;
        if (as) begin
            s  = {1'b0, a} + {1'b0, b};
            y  = s[15:0];
            c  = s[16];
            ov = sgn & (a[15] == b[15]) & (y[15] != a[15]);
        end else begin
            y  = a - b;
            c  = (a < b);
            ov = sgn & (a[15] != b[15]) & (y[15] != a[15]);
        end
        return {c, ov, y};
    endfunction

    assign {rr_alu_carry, rr_alu_over, rr_alu_y} = adder(rr_alu_a, rr_alu_b, rr_alu_as, rr_alu_sign);
    assign {fp_alu_carry, fp_alu_over, fp_alu_y} = adder(fp_alu_a, fp_alu_b, fp_alu_as, fp_alu_sign);

    addsub_arb #(.RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_add(r0_add), .r1_add(r1_add), .r0_sign(r0_sign), .r1_sign(r1_sign),
        .r0_gnt(rr_r0_gnt), .r1_gnt(rr_r1_gnt), .r0_done(rr_r0_done), .r1_done(rr_r1_done),
        .r0_y(rr_r0_y), .r1_y(rr_r1_y),
        .r0_carry(rr_r0_carry), .r1_carry(rr_r1_carry), .r0_over(rr_r0_over), .r1_over(rr_r1_over),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_as(rr_alu_as), .alu_sign(rr_alu_sign),
        .alu_y(rr_alu_y), .alu_carry(rr_alu_carry), .alu_over(rr_alu_over),
        .busy(rr_busy), .op_cnt(rr_op_cnt)
    );

    addsub_arb #(.RR(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r1_req(r1_req),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_add(r0_add), .r1_add(r1_add), .r0_sign(r0_sign), .r1_sign(r1_sign),
        .r0_gnt(fp_r0_gnt), .r1_gnt(fp_r1_gnt), .r0_done(fp_r0_done), .r1_done(fp_r1_done),
        .r0_y(fp_r0_y), .r1_y(fp_r1_y),
        .r0_carry(fp_r0_carry), .r1_carry(fp_r1_carry), .r0_over(fp_r0_over), .r1_over(fp_r1_over),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_as(fp_alu_as), .alu_sign(fp_alu_sign),
        .alu_y(fp_alu_y), .alu_carry(fp_alu_carry), .alu_over(fp_alu_over),
        .busy(fp_busy), .op_cnt(fp_op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [17:0] e;
        logic        p;
        rst_n   = 1'b0;
        r0_req  = 1'b0; r1_req  = 1'b0;
        r0_a    = 16'h0; r0_b = 16'h0; r1_a = 16'h0; r1_b = 16'h0;
        r0_add  = 1'b0; r1_add  = 1'b0; r0_sign = 1'b0; r1_sign = 1'b0;
        #12;
        // reset state
        chk("rst_pulses", {rr_r0_gnt, rr_r1_gnt, rr_r0_done, rr_r1_done, rr_busy}, 32'h0);
        chk("rst_alu", {rr_alu_a, rr_alu_b}, 32'h0);
        chk("rst_alu_ctl", {rr_alu_as, rr_alu_sign}, 32'h0);
        chk("rst_y", {rr_r0_y, rr_r1_y}, 32'h0);
        chk("rst_flags", {rr_r0_carry, rr_r1_carry, rr_r0_over, rr_r1_over}, 32'h0);
        chk("rst_op_cnt", rr_op_cnt, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // single unsigned add on port 0: FFFF + 1
        r0_req = 1'b1; r0_a = 16'hFFFF; r0_b = 16'h0001; r0_add = 1'b1; r0_sign = 1'b0;
        tick();
        chk("add_gnt", {rr_r0_gnt, rr_r1_gnt, rr_busy}, 32'b101);
        chk("add_alu_a", rr_alu_a, 32'hFFFF);
        r0_req = 1'b0;
        tick();
        chk("add_done", {rr_r0_done, rr_r1_done, rr_r0_gnt, rr_busy}, 32'b1000);
        chk("add_y", rr_r0_y, 32'h0000);
        chk("add_flags", {rr_r0_carry, rr_r0_over}, 32'b10);
        chk("add_op_cnt", rr_op_cnt, 32'd1);
        tick();
        chk("add_done_pulse", rr_r0_done, 32'h0);

        // signed subtract on port 1: 0x8000 - 1
        r1_req = 1'b1; r1_a = 16'h8000; r1_b = 16'h0001; r1_add = 1'b0; r1_sign = 1'b1;
        tick();
        chk("sub_gnt", {rr_r0_gnt, rr_r1_gnt}, 32'b01);
        r1_req = 1'b0;
        tick();
        chk("sub_done", {rr_r0_done, rr_r1_done}, 32'b01);
        chk("sub_y", rr_r1_y, 32'h7FFF);
        chk("sub_flags", {rr_r1_carry, rr_r1_over}, 32'b01);
        chk("sub_r0_kept", {rr_r0_y, 15'h0, rr_r0_carry}, 32'h1);
        chk("sub_op_cnt", rr_op_cnt, 32'd2);
        tick();

        // both ports requesting continuously for 6 operations
        r0_a = 16'h1234; r0_b = 16'h0011; r0_add = 1'b1; r0_sign = 1'b0;
        r1_a = 16'h0100; r1_b = 16'h0101; r1_add = 1'b0; r1_sign = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            p = k[0];
            chk("rr_gnt", {rr_r0_gnt, rr_r1_gnt}, {30'h0, ~p, p});
            chk("fp_gnt", {fp_r0_gnt, fp_r1_gnt}, 32'b10);
            e = p ? adder(r1_a, r1_b, 1'b0, 1'b0) : adder(r0_a, r0_b, 1'b1, 1'b0);
            if (p) r1_a = r1_a + 16'h0111;
            else   r0_a = r0_a + 16'h0111;
            tick();
            chk("rr_done", {rr_r0_done, rr_r1_done, rr_r0_gnt, rr_r1_gnt}, {28'h0, ~p, p, 2'b00});
            chk("rr_res", p ? {13'h0, rr_r1_carry, rr_r1_over, rr_r1_y} : {13'h0, rr_r0_carry, rr_r0_over, rr_r0_y},
                {14'h0, e});
        end
        chk("rr_op_cnt", rr_op_cnt, 32'd8);
        chk("fp_r1_untouched", fp_r1_y, 32'h7FFF);

        // drop port 0: fixed-priority instance now grants port 1
        r0_req = 1'b0;
        tick();
        chk("fp_gnt_r1", {fp_r0_gnt, fp_r1_gnt}, 32'b01);
        chk("rr_gnt_r1", {rr_r0_gnt, rr_r1_gnt}, 32'b01);
        r1_req = 1'b0;
        tick();
        chk("fp_done_r1", fp_r1_done, 32'h1);
        chk("fp_op_cnt", fp_op_cnt, 32'd9);
        tick();

        // op_cnt wrap
        force u_rr.op_cnt = 16'hFFFE;
        #1;
        release u_rr.op_cnt;
        r0_req = 1'b1; r0_a = 16'h0002; r0_b = 16'h0003; r0_add = 1'b1;
        tick();
        tick();
        chk("wrap_ffff", rr_op_cnt, 32'hFFFF);
        tick();
        r0_req = 1'b0;
        tick();
        chk("wrap_zero", rr_op_cnt, 32'h0000);
        chk("wrap_y", rr_r0_y, 32'h0005);
        tick();

        // reset during EXEC abandons the operation
        r0_req = 1'b1; r0_a = 16'h4000; r0_b = 16'h4000; r0_add = 1'b1; r0_sign = 1'b1;
        tick();
        chk("mid_gnt", {rr_r0_gnt, rr_busy}, 32'b11);
        r0_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulses", {rr_r0_gnt, rr_r1_gnt, rr_r0_done, rr_r1_done, rr_busy}, 32'h0);
        chk("mid_rst_state", {rr_op_cnt, rr_alu_a}, 32'h0);
        tick();
        chk("mid_rst_no_done", {rr_r0_done, rr_r0_over, 14'h0, rr_r0_y}, 32'h0);
        rst_n = 1'b1;
        tick();

        // first tie after reset goes to port 0
        r0_req = 1'b1; r1_req = 1'b1;
        r0_a = 16'h0001; r0_b = 16'h0001; r0_add = 1'b1; r0_sign = 1'b0;
        tick();
        chk("post_rst_tie", {rr_r0_gnt, rr_r1_gnt}, 32'b10);
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
        chk("post_rst_done", {rr_r0_done, rr_r0_y}, {15'h0, 1'b1, 16'h0002});
        chk("post_rst_cnt", rr_op_cnt, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
